seg7_scan_ctrl: RTL and testbench
=================================

Name: seg7_scan_ctrl

Overview:
Time-multiplexed scan controller for a multi-digit common-anode/cathode 7-segment display. It shares one bcd_7seg decoder across NUM_DIGITS digits: it presents one BCD code per slot on bcd_out, which drives the shared decoder, and drives a one-hot digit enable. It also provides anti-ghosting blanking, frame-synchronous data update, leading-zero suppression and invalid-code blanking.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8); digit 0 = least significant
REFRESH_DIV, 1000, clock cycles each digit is lit per slot (>=1)
BLANK_CYCLES, 2, clock cycles all digits are dark before each slot (>=1)

Ports:
clk  input  1  system clock, all state on rising edge
rst  input  1  asynchronous, active-high reset
bcd_in  input  4*NUM_DIGITS  display value, digit i at bits [4i+3:4i]
dp_in  input  NUM_DIGITS  decimal-point request per digit
load  input  1  capture bcd_in/dp_in/lz_en for display
lz_en  input  1  leading-zero suppression enable
bcd_out  output  4  BCD code to shared decoder for current digit
dig_en  output  NUM_DIGITS  one-hot active-high digit enable
dp_out  output  1  decimal point for current digit
frame_done  output  1  one-cycle pulse at end of each full scan
err  output  1  sticky: displayed data contains a code > 9

Behaviour:
- Reset (async, rst=1): state=BLANK, idx=0, phase counter=0, shadow and pending registers=0, pending_valid=0; outputs: bcd_out=0, dig_en=0, dp_out=0, frame_done=0, err=0.
- FSM states:
  - BLANK: lasts BLANK_CYCLES cycles; dig_en=0; bcd_out and dp_out show shadow[idx]. After the last BLANK cycle, go to SHOW.
  - SHOW: lasts REFRESH_DIV cycles; dig_en[idx]=1 unless the digit is suppressed. After the last SHOW cycle, go to BLANK with idx+1.
- Index wrap: idx wraps NUM_DIGITS-1 -> 0. frame_done=1 for exactly the first BLANK cycle of idx 0 after a wrap, not after reset.
- Frame length: NUM_DIGITS*(BLANK_CYCLES+REFRESH_DIV) cycles.
- Outputs are registered. bcd_out/dp_out change only on entry to BLANK, never while dig_en is non-zero.
- Load and tear-free update:
  - load=1 copies bcd_in, dp_in and lz_en into pending and sets pending_valid.
  - Shadow is updated only on the wrap edge (entry to BLANK of idx 0). If pending_valid, shadow<=pending and pending_valid is cleared.
  - If load=1 on the wrap cycle itself, bcd_in/dp_in/lz_en go straight into shadow; this takes priority.
  - Repeated loads within a frame: the last one wins.
- Leading-zero suppression (lz_en latched in shadow): digit i>0 is suppressed when it and all higher digits are 0. Digit 0 is never suppressed. A suppressed digit keeps dig_en=0 and dp_out=0 for its whole SHOW, but slot timing is unchanged.
- Invalid code (shadow digit > 9):
  - That digit's dig_en stays 0 and bcd_out=4'b1111.
  - err goes to 1 at that digit's BLANK entry.
  - err clears only when shadow is updated with all-valid data.
- Mid-operation reset: all outputs go to their reset values immediately, asynchronously. Scanning restarts at idx 0 BLANK after rst deasserts.

Test Plan:
- Setup for all cases: NUM_DIGITS=4, REFRESH_DIV=4, BLANK_CYCLES=1, so each frame is 20 cycles.
- Reset then load 0x1234, lz_en=0 -> dig_en sequence 0000,0001x4,0000,0010x4,0000,0100x4,0000,1000x4; bcd_out 4,3,2,1; frame_done pulses every 20 cycles.
- Load 0x0056 with lz_en=1 -> digits 0,1 lit showing 6,5; dig_en[3:2] never asserted; slot timing stays 20 cycles per frame.
- Load 0x9999 mid-frame (idx=2) -> bcd_out stays old data until the wrap; new data first appears on idx 0 of the next frame. Load on the wrap cycle -> new data is used in that same frame.
- Load 0x12F4 -> digit 1 dark with bcd_out=1111; err=1 from that slot on; then load 0x0000 -> err=0 after the next wrap, and digit 0 shows 0 with lz_en=1.
- Assert rst during SHOW of idx 2 -> dig_en=0, bcd_out=0, err=0 in the same cycle; after release, the first slot is idx 0 BLANK and frame_done stays 0 until the first wrap.

Source files
------------

// File: rtl/seg7_scan_ctrl.sv
// Multiplexed 7-segment scan controller: one shared BCD decoder, blanked slot
// transitions, frame-synchronous shadow update, leading-zero and invalid-code blanking.

module seg7_scan_lane #(
  parameter bit IS_LSD = 1'b0
) (
  input  logic [3:0] code,
  input  logic       upper_zero,
  input  logic       lz_en,
  output logic       valid,
  output logic       supp
);
  assign valid = (code <= 4'd9);
  // the least significant digit always shows, even when the whole value is zero
  assign supp  = lz_en && !IS_LSD && upper_zero && (code == 4'd0);
endmodule

module seg7_scan_ctrl #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 1000,
  parameter int BLANK_CYCLES = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [4*NUM_DIGITS-1:0] bcd_in,
  input  logic [NUM_DIGITS-1:0]   dp_in,
  input  logic                    load,
  input  logic                    lz_en,
  output logic [3:0]              bcd_out,
  output logic [NUM_DIGITS-1:0]   dig_en,
  output logic                    dp_out,
  output logic                    frame_done,
  output logic                    err
);
  localparam int IW   = $clog2(NUM_DIGITS);
  localparam int CMAX = (REFRESH_DIV > BLANK_CYCLES) ? REFRESH_DIV : BLANK_CYCLES;
  localparam int CW   = $clog2(CMAX + 1);

  typedef struct packed {
    logic [NUM_DIGITS-1:0][3:0] code;
    logic [NUM_DIGITS-1:0]      dp;
    logic                       lz;
  } disp_t;

  typedef enum logic {BLANK, SHOW} state_t;

  state_t          state, state_nx;
  logic [IW-1:0]   idx, idx_nx;
  logic [CW-1:0]   cnt, cnt_nx;
  disp_t           shadow, pending, in_req, sh_nx;
  logic            pend_vld;
  logic            blank_entry, show_entry, wrap, sh_upd;
  logic [NUM_DIGITS-1:0] valid, supp, upz;

  assign in_req = {bcd_in, dp_in, lz_en};

  // Lane flags follow the shadow as it will be after this edge, so the
  // outputs registered on the wrap edge already reflect freshly loaded data.
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_lane
    if (g == NUM_DIGITS-1) begin : g_top
      assign upz[g] = 1'b1;
    end else begin : g_low
      assign upz[g] = upz[g+1] && (sh_nx.code[g+1] == 4'd0);
    end
    seg7_scan_lane #(.IS_LSD(g == 0)) u_lane (
      .code       (sh_nx.code[g]),
      .upper_zero (upz[g]),
      .lz_en      (sh_nx.lz),
      .valid      (valid[g]),
      .supp       (supp[g])
    );
  end

  always_comb begin
    state_nx    = state;
    idx_nx      = idx;
    cnt_nx      = cnt + 1'b1;
    blank_entry = 1'b0;
    show_entry  = 1'b0;
    unique case (state)
      BLANK: if (cnt == CW'(BLANK_CYCLES-1)) begin
        state_nx   = SHOW;
        cnt_nx     = '0;
        show_entry = 1'b1;
      end
      SHOW: if (cnt == CW'(REFRESH_DIV-1)) begin
        state_nx    = BLANK;
        cnt_nx      = '0;
        blank_entry = 1'b1;
        idx_nx      = (idx == IW'(NUM_DIGITS-1)) ? '0 : idx + 1'b1;
      end
    endcase
    wrap   = blank_entry && (idx == IW'(NUM_DIGITS-1));
    sh_nx  = shadow;
    sh_upd = 1'b0;
    if (wrap && load) begin
      sh_nx  = in_req;
      sh_upd = 1'b1;
    end else if (wrap && pend_vld) begin
      sh_nx  = pending;
      sh_upd = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= BLANK;
      idx        <= '0;
      cnt        <= '0;
      shadow     <= '0;
      pending    <= '0;
      pend_vld   <= 1'b0;
      bcd_out    <= '0;
      dig_en     <= '0;
      dp_out     <= 1'b0;
      frame_done <= 1'b0;
      err        <= 1'b0;
    end else begin
      state      <= state_nx;
      idx        <= idx_nx;
      cnt        <= cnt_nx;
      shadow     <= sh_nx;
      frame_done <= wrap;
      if (wrap) begin
        pend_vld <= 1'b0;
      end else if (load) begin
        pending  <= in_req;
        pend_vld <= 1'b1;
      end
      if (blank_entry) begin
        dig_en  <= '0;
        bcd_out <= valid[idx_nx] ? sh_nx.code[idx_nx] : 4'hF;
        dp_out  <= sh_nx.dp[idx_nx] && !supp[idx_nx];
        if (sh_upd && (&valid))
          err <= 1'b0;
        else if (!valid[idx_nx])
          err <= 1'b1;
      end else if (show_entry) begin
        dig_en <= (valid[idx] && !supp[idx]) ? (NUM_DIGITS'(1) << idx) : '0;
      end
    end
  end
endmodule

// File: tb/tb_seg7_scan_ctrl.sv
// Directed bench for seg7_scan_ctrl: 4 digits, 4-cycle slots, 1-cycle blank (20-cycle frames).

module tb_seg7_scan_ctrl;
  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] bcd_in;
  logic [3:0]  dp_in;
  logic        load;
  logic        lz_en;
  logic [3:0]  bcd_out;
  logic [3:0]  dig_en;
  logic        dp_out;
  logic        frame_done;
  logic        err;

  int checks = 0;
  int errs   = 0;
  int frm    = 0;

  seg7_scan_ctrl #(.NUM_DIGITS(4), .REFRESH_DIV(4), .BLANK_CYCLES(1)) dut (
    .clk        (clk),
    .rst        (rst),
    .bcd_in     (bcd_in),
    .dp_in      (dp_in),
    .load       (load),
    .lz_en      (lz_en),
    .bcd_out    (bcd_out),
    .dig_en     (dig_en),
    .dp_out     (dp_out),
    .frame_done (frame_done),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errs++;
      $display("FAIL %s frame=%0d t=%0t: got %h want %h", tag, frm, $time, got, exp);
    end
  endtask

  // Steps through one frame starting at slot-0 BLANK, checking every cycle;
  // optionally pulses load at position ld_pos and stops early at position stop.
  task automatic run_frame(input logic [15:0] bcd_e, input logic [3:0] lit,
                           input logic [3:0] dp_e, input logic fd0,
                           input logic err0, input int err_pos, input int stop,
                           input int ld_pos, input logic [15:0] ld_bcd,
                           input logic [3:0] ld_dp, input logic ld_lz);
    int s;
    logic [3:0] en_e;
    for (int p = 0; p < stop; p++) begin
      s = p / 5;
      en_e = ((p % 5) == 0 || !lit[s]) ? 4'b0000 : 4'(1 << s);
      chk("dig_en", 16'(dig_en), 16'(en_e));
      chk("bcd_out", 16'(bcd_out), 16'(bcd_e[4*s +: 4]));
      chk("dp_out", 16'(dp_out), 16'(dp_e[s]));
      chk("frame_done", 16'(frame_done), (p == 0) ? 16'(fd0) : 16'd0);
      chk("err", 16'(err), (err_pos >= 0 && p >= err_pos) ? 16'd1 : 16'(err0));
      if (p == ld_pos) begin
        bcd_in = ld_bcd;
        dp_in  = ld_dp;
        lz_en  = ld_lz;
        load   = 1'b1;
      end
      @(negedge clk);
      load = 1'b0;
    end
    frm++;
  endtask

  initial begin
    rst    = 1'b1;
    load   = 1'b0;
    lz_en  = 1'b0;
    bcd_in = '0;
    dp_in  = '0;
    @(negedge clk);
    chk("rst_bcd", 16'(bcd_out), 16'd0);
    chk("rst_en", 16'(dig_en), 16'd0);
    chk("rst_dp", 16'(dp_out), 16'd0);
    chk("rst_fd", 16'(frame_done), 16'd0);
    chk("rst_err", 16'(err), 16'd0);
    @(negedge clk);
    rst = 1'b0;

    // F0: reset shadow (all zero, no suppression); queue 1234 with dp on digit 2
    run_frame(16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b0, -1, 20, 0, 16'h1234, 4'b0100, 1'b0);
    // F1: 1234 shown; 0056 loaded mid-frame (slot 2) must not tear this frame
    run_frame(16'h1234, 4'b1111, 4'b0100, 1'b1, 1'b0, -1, 20, 12, 16'h0056, 4'b0000, 1'b1);
    // F2: 0056 with suppression; 9999 loaded on the wrap cycle
    run_frame(16'h0056, 4'b0011, 4'b0000, 1'b1, 1'b0, -1, 20, 19, 16'h9999, 4'b1111, 1'b0);
    // F3: 9999 used immediately; queue 12F4
    run_frame(16'h9999, 4'b1111, 4'b1111, 1'b1, 1'b0, -1, 20, 7, 16'h12F4, 4'b0000, 1'b0);
    // F4: digit 1 invalid -> dark, bcd F, err from slot 1; queue all-zero with lz
    run_frame(16'h12F4, 4'b1101, 4'b0000, 1'b1, 1'b0, 5, 20, 3, 16'h0000, 4'b0000, 1'b1);
    // F5: err cleared at wrap, only digit 0 lit showing 0; queue 12F4 again
    run_frame(16'h0000, 4'b0001, 4'b0000, 1'b1, 1'b0, -1, 20, 0, 16'h12F4, 4'b0000, 1'b0);
    // F6: run into slot-2 SHOW, then reset mid-slot
    run_frame(16'h12F4, 4'b1101, 4'b0000, 1'b1, 1'b0, 5, 12, -1, 16'h0000, 4'b0000, 1'b0);
    chk("pre_rst_en", 16'(dig_en), 16'h0004);
    chk("pre_rst_err", 16'(err), 16'd1);
    rst = 1'b1;
    #1;
    chk("async_en", 16'(dig_en), 16'd0);
    chk("async_bcd", 16'(bcd_out), 16'd0);
    chk("async_err", 16'(err), 16'd0);
    chk("async_dp", 16'(dp_out), 16'd0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    // F7: restart from idx 0 BLANK, no frame_done until the first wrap
    run_frame(16'h0000, 4'b1111, 4'b0000, 1'b0, 1'b0, -1, 20, -1, 16'h0000, 4'b0000, 1'b0);
    run_frame(16'h0000, 4'b1111, 4'b0000, 1'b1, 1'b0, -1, 1, -1, 16'h0000, 4'b0000, 1'b0);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule
